// File: rtl/legv8_mc_if.sv
// Bundle between the LEGv8 multicycle control unit and the datapath it steers.
// The control unit takes the master side. The datapath (or a bench) takes the slave side.
interface legv8_mc_if #(
  parameter int CNT_W = 32
);
  logic [10:0]      opcode;
  logic             zero;
  logic             mem_ready;
  logic [3:0]       ALUctr;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       imm_sel;
  logic             ir_write;
  logic             mem_read;
  logic             mem_write;
  logic             reg_write;
  logic             mem_to_reg;
  logic             reg2loc;
  logic             pc_source;
  logic             pc_en;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;
  logic [3:0]       state;

  modport master (
    input  opcode, zero, mem_ready,
    output ALUctr, alu_src_a, alu_src_b, imm_sel, ir_write, mem_read, mem_write,
           reg_write, mem_to_reg, reg2loc, pc_source, pc_en, illegal, instr_count, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  ALUctr, alu_src_a, alu_src_b, imm_sel, ir_write, mem_read, mem_write,
           reg_write, mem_to_reg, reg2loc, pc_source, pc_en, illegal, instr_count, state
  );
endinterface

// File: rtl/legv8_mc_control.sv
// Moore-style multicycle control FSM for the LEGv8 datapath.
// Outputs are decoded from the current state. The strobes are forced low while reset is held.
module legv8_mc_control #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  legv8_mc_if.master  bus
);

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    WB_MEM   = 4'd4,
    MEM_WR   = 4'd5,
    RTYPE_EX = 4'd6,
    RTYPE_WB = 4'd7,
    CBZ_EX   = 4'd8,
    BRANCH   = 4'd9,
    ILLEGAL  = 4'd15
  } state_t;

  state_t           cur_state;
  state_t           nxt_state;
  logic [CNT_W-1:0] count;
  logic             retire;

  logic             is_rtype;
  logic             is_ldur;
  logic             is_stur;
  logic             is_cbz;
  logic             is_b;

  logic [3:0]       alu_ctr;
  logic [1:0]       src_a;
  logic [1:0]       src_b;
  logic [1:0]       imm;
  logic             raw_ir_write;
  logic             raw_mem_read;
  logic             raw_mem_write;
  logic             raw_reg_write;
  logic             raw_pc_en;
  logic             wb_mem;
  logic             pc_src;
  logic             trap;

  function automatic logic [3:0] rtype_alu(input logic [10:0] op);
    logic [3:0] ctr;
    case (op)
      OP_ADD:  ctr = 4'b0010;
      OP_SUB:  ctr = 4'b0110;
      OP_AND:  ctr = 4'b0000;
      OP_ORR:  ctr = 4'b0001;
      default: ctr = 4'b0010;
    endcase
    return ctr;
  endfunction

  assign is_rtype = (bus.opcode == OP_ADD) || (bus.opcode == OP_SUB) ||
                    (bus.opcode == OP_AND) || (bus.opcode == OP_ORR);
  assign is_ldur  = (bus.opcode == OP_LDUR);
  assign is_stur  = (bus.opcode == OP_STUR);
  assign is_cbz   = (bus.opcode[10:3] == 8'b10110100);
  assign is_b     = (bus.opcode[10:5] == 6'b000101);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= FETCH;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Retired-instruction counter; wraps freely.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= {CNT_W{1'b0}};
    end else if (retire) begin
      count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  // Next-state and per-state output decode.
  always_comb begin
    nxt_state     = cur_state;
    retire        = 1'b0;
    alu_ctr       = 4'b0000;
    src_a         = 2'b00;
    src_b         = 2'b00;
    imm           = 2'b00;
    raw_ir_write  = 1'b0;
    raw_mem_read  = 1'b0;
    raw_mem_write = 1'b0;
    raw_reg_write = 1'b0;
    raw_pc_en     = 1'b0;
    wb_mem        = 1'b0;
    pc_src        = 1'b0;
    trap          = 1'b0;
    case (cur_state)
      FETCH: begin
        raw_mem_read = 1'b1;
        src_b        = 2'b01;
        alu_ctr      = 4'b0010;
        raw_ir_write = bus.mem_ready;
        raw_pc_en    = bus.mem_ready;
        nxt_state    = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        // ALUOut captures PC + (imm << 2) as the speculative branch target.
        src_b   = 2'b11;
        alu_ctr = 4'b0010;
        if (is_cbz) begin
          imm = 2'b01;
        end else if (is_b) begin
          imm = 2'b10;
        end else begin
          imm = 2'b00;
        end
        if (is_rtype) begin
          nxt_state = RTYPE_EX;
        end else if (is_ldur || is_stur) begin
          nxt_state = MEM_ADDR;
        end else if (is_cbz) begin
          nxt_state = CBZ_EX;
        end else if (is_b) begin
          nxt_state = BRANCH;
        end else begin
          nxt_state = ILLEGAL;
        end
      end
      MEM_ADDR: begin
        src_a   = 2'b01;
        src_b   = 2'b10;
        alu_ctr = 4'b0010;
        if (is_ldur) begin
          nxt_state = MEM_RD;
        end else if (is_stur) begin
          nxt_state = MEM_WR;
        end else begin
          nxt_state = ILLEGAL;
        end
      end
      MEM_RD: begin
        raw_mem_read = 1'b1;
        nxt_state    = bus.mem_ready ? WB_MEM : MEM_RD;
      end
      WB_MEM: begin
        raw_reg_write = 1'b1;
        wb_mem        = 1'b1;
        retire        = 1'b1;
        nxt_state     = FETCH;
      end
      MEM_WR: begin
        raw_mem_write = 1'b1;
        retire        = bus.mem_ready;
        nxt_state     = bus.mem_ready ? FETCH : MEM_WR;
      end
      RTYPE_EX: begin
        src_a     = 2'b01;
        alu_ctr   = rtype_alu(bus.opcode);
        nxt_state = RTYPE_WB;
      end
      RTYPE_WB: begin
        raw_reg_write = 1'b1;
        alu_ctr       = rtype_alu(bus.opcode);
        retire        = 1'b1;
        nxt_state     = FETCH;
      end
      CBZ_EX: begin
        // The ALU passes 0 | Rt so that zero reflects Rt == 0.
        src_a     = 2'b10;
        alu_ctr   = 4'b0001;
        pc_src    = 1'b1;
        raw_pc_en = bus.zero;
        retire    = 1'b1;
        nxt_state = FETCH;
      end
      BRANCH: begin
        pc_src    = 1'b1;
        raw_pc_en = 1'b1;
        retire    = 1'b1;
        nxt_state = FETCH;
      end
      ILLEGAL: begin
        trap      = 1'b1;
        nxt_state = ILLEGAL;
      end
      default: begin
        nxt_state = FETCH;
      end
    endcase
  end

  assign bus.ALUctr      = alu_ctr;
  assign bus.alu_src_a   = src_a;
  assign bus.alu_src_b   = src_b;
  assign bus.imm_sel     = imm;
  assign bus.ir_write    = raw_ir_write  & ~reset;
  assign bus.mem_read    = raw_mem_read  & ~reset;
  assign bus.mem_write   = raw_mem_write & ~reset;
  assign bus.reg_write   = raw_reg_write & ~reset;
  assign bus.pc_en       = raw_pc_en     & ~reset;
  assign bus.mem_to_reg  = wb_mem;
  assign bus.reg2loc     = is_stur | is_cbz;
  assign bus.pc_source   = pc_src;
  assign bus.illegal     = trap;
  assign bus.instr_count = count;
  assign bus.state       = cur_state;

endmodule

// File: doc/legv8_mc_control.md
Name: legv8_mc_control

Overview:
- Multicycle control unit for the LEGv8 datapath. It is the producer side of the 4-bit ALU control interface: it decodes the 11-bit opcode and drives ALUctr, operand selects, memory/register strobes and PC enables each cycle.
- It also consumes the ALU Zero flag for CBZ.
- It sits between the instruction register and the shared 64-bit ALU, register file, unified memory and PC.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  11  IR[31:21]; valid from DECODE onward.
- zero  in  1  ALU Zero flag, same cycle.
- mem_ready  in  1  memory completes the current read/write this cycle.
- ALUctr  out  4  ALU operation: 0000 AND, 0001 ORR, 0010 ADD, 0110 SUB.
- alu_src_a  out  2  A operand: 00 PC, 01 Rn data, 10 constant 0.
- alu_src_b  out  2  B operand: 00 Rm/Rt data, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm<<2.
- imm_sel  out  2  immediate field: 00 D-type [20:12], 01 CB [23:5], 10 B [25:0].
- ir_write  out  1  latch instruction register.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- reg_write  out  1  register file write.
- mem_to_reg  out  1  write-back source: 1 memory data, 0 ALUOut.
- reg2loc  out  1  second read port selects Rt (1) or Rm (0).
- pc_source  out  1  PC input: 0 live ALU result, 1 ALUOut register.
- pc_en  out  1  PC load enable.
- illegal  out  1  unsupported opcode trapped.
- instr_count  out  CNT_W  retired-instruction count.
- state  out  4  current state, for debug.

Behaviour:
- Moore FSM. State is registered; outputs are decoded combinationally from state. Exceptions: pc_en and ir_write also gate on mem_ready/zero, and reg2loc/ALUctr use opcode.
- Unlisted outputs are 0 in every state.
- Reset (asynchronous, any time including mid-memory transaction): state=FETCH(0), instr_count=0. While reset is high all strobes are 0. An aborted memory request is simply dropped.
- FETCH(0):
  - Outputs: mem_read=1, alu_src_a=00, alu_src_b=01, ALUctr=0010, pc_source=0, ir_write=pc_en=mem_ready.
  - Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE(1): alu_src_a=00, alu_src_b=11, ALUctr=0010, computing the branch target into ALUOut. imm_sel=01 for CBZ, 10 for B, 00 otherwise. Next state:
  - ADD 10001011000 / SUB 11001011000 / AND 10001010000 / ORR 10101010000 -> RTYPE_EX.
  - LDUR 11111000010 / STUR 11111000000 -> MEM_ADDR.
  - CBZ 10110100xxx -> CBZ.
  - B 000101xxxxx -> BRANCH.
  - Anything else -> ILLEGAL.
- MEM_ADDR(2): alu_src_a=01, alu_src_b=10, imm_sel=00, ALUctr=0010. Go to MEM_RD for LDUR, MEM_WR for STUR.
- MEM_RD(3): mem_read=1. Hold until mem_ready=1, then go to WB_MEM.
- WB_MEM(4): reg_write=1, mem_to_reg=1. Go to FETCH (retire).
- MEM_WR(5): mem_write=1. Hold until mem_ready=1, then go to FETCH (retire).
- RTYPE_EX(6): alu_src_a=01, alu_src_b=00. ALUctr by opcode: ADD 0010, SUB 0110, AND 0000, ORR 0001. Go to RTYPE_WB.
- RTYPE_WB(7): reg_write=1, mem_to_reg=0, ALUctr held. Go to FETCH (retire).
- CBZ(8): alu_src_a=10, alu_src_b=00, ALUctr=0001 (0 | Rt), pc_source=1, pc_en=zero. Go to FETCH (retire) regardless of zero.
- BRANCH(9): pc_source=1, pc_en=1. Go to FETCH (retire).
- ILLEGAL(15): illegal=1, all strobes 0. Sticky until reset; no retirement.
- reg2loc=1 whenever opcode is STUR or CBZ, in every state.
- instr_count increments by 1 on each retiring transition. Wraps modulo 2^CNT_W with no saturation.
- Latencies, with mem_ready=1 on first request:
  - R-type: 4 cycles.
  - LDUR: 5 cycles.
  - STUR: 4 cycles.
  - CBZ: 3 cycles.
  - B: 3 cycles.
  - Each mem_ready=0 cycle adds one cycle.
- Unused state codes (10-14) go to FETCH on the next edge.

Test Plan:
- Reset asserted mid-MEM_RD with mem_ready=0 -> state=0, mem_read drops in the same cycle without waiting for a clock edge, instr_count=0. After release, FETCH resumes.
- ADD then SUB, mem_ready=1 -> each 4 cycles. ALUctr=0010 then 0110 in RTYPE_EX. reg_write=1 exactly one cycle each. instr_count=2 after 8 cycles.
- LDUR with mem_ready low 3 cycles in MEM_RD -> 8 cycles total. mem_read held 4 cycles in MEM_RD. mem_to_reg=1 and reg_write=1 in WB_MEM.
- CBZ with zero=1, then CBZ with zero=0 -> pc_en=1, pc_source=1 in the first CBZ state. pc_en=0 in the second. Both retire; reg2loc=1 throughout.
- Opcode 11111111111 -> ILLEGAL: illegal=1 held for 20 cycles, all strobes 0, count frozen. Only reset clears it.
- instr_count preset near wrap (CNT_W=4 build, 16 retirements) -> count reads 0 after the 16th retirement.
